data_cache: RTL
===============

# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the pipeline's memory-access stage and `data_memory`. Load hits return byte/half/word data, extended per `func3`, in the request cycle. Load misses stall the pipeline while a 4-word line is filled from `data_memory` one word per cycle. Stores always go straight through to `data_memory` and update the cached copy on a hit.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `SETS`, 16, number of lines (power of two)
- `LINE_WORDS`, 4, words per line (fixed)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  memory-stage access this cycle
- `req_write`  in  1  1 = store, 0 = load
- `func3`  in  3  RV32I load/store `func3`
- `address`  in  ADDR_WIDTH  byte address
- `write_data`  in  DATA_WIDTH  store data, LSB-aligned
- `read_data`  out  DATA_WIDTH  extended load result
- `stall`  out  1  hold the pipeline; request must stay stable
- `misaligned`  out  1  current request is misaligned and ignored
- `mem_address`  out  ADDR_WIDTH  to `data_memory.address`
- `mem_func3`  out  3  to `data_memory.func3`
- `mem_write_enable`  out  1  to `data_memory.write_enable`
- `mem_write_data`  out  DATA_WIDTH  to `data_memory.write_data`
- `mem_read_data`  in  DATA_WIDTH  from `data_memory.data_out` (combinational)

## Operation
- Address split: offset [1:0], word [3:2], index [3+log2(SETS):4], tag = remaining upper bits.
- Storage per set: valid bit, tag, 4 data words.
- Alignment:
  - `misaligned` = req_valid & ((half access & address[0]) | (word access & address[1:0] != 0)).
  - A misaligned request changes no state, writes no memory, does not stall, and returns `read_data` = 0.
- Load `func3` handling:
  - 0 LB and 4 LBU select the byte at offset.
  - 1 LH and 5 LHU select the half at offset[1].
  - 2 LW selects the whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Other `func3` values: `read_data` = 0, no fill.
- Store path (IDLE only, never stalls):
  - `mem_write_enable` = 1 and `mem_func3` = `func3`, driven combinationally.
  - `mem_address` = `address`, `mem_write_data` = `write_data`.
  - On a hit, the cached bytes selected by `func3` (0 SB, 1 SH, 2 SW) are updated at the same edge.
  - On a miss, cache contents are unchanged.
- FSM states: IDLE, FILL.
  - IDLE → FILL when there is an aligned load with tag mismatch or an invalid line. `stall` = 1 in that same cycle.
  - FILL: a 2-bit word counter runs 0..3. `mem_address` = {tag, index, cnt, 2'b00}, `mem_func3` = 3'h2, `mem_write_enable` = 0. Each edge writes `mem_read_data` into word cnt. The edge at cnt = 3 sets valid and tag, then returns to IDLE.
  - Outside a store or fill, `mem_write_enable` = 0 and `mem_address` = `address`.
- `stall` = (state == FILL) | (IDLE & aligned load miss).
- While `stall` = 1, the pipeline must hold the request stable. A changed request during a stall is a protocol violation with unspecified result.

## Timing
- Load hit: 0 extra cycles; `read_data` is valid combinationally in the request cycle.
- Load miss: the request cycle plus 3 further FILL cycles, so `stall` is high for 4 cycles. The hit in the 5th cycle returns data with `stall` = 0.
- Store: 1 cycle, and `data_memory` commits at that edge.
- Reset (async):
  - All valid bits cleared, state = IDLE, counter = 0.
  - While `rst` = 1, `stall` = 0, `mem_write_enable` = 0, `read_data` = 0 and `misaligned` = 0.
- Reset during FILL abandons the line. It stays invalid, and a later access refills it from word 0.

## Structure
- `cache_pkg`:
  - `state_t` enum {IDLE, FILL}.
  - `func3` localparams F3_B/H/W/BU/HU.
  - `LINE_WORDS` and offset widths.
- Sub-module `load_align`: combinational word + offset + `func3` → extended `read_data`, with zero output for illegal codes.
- The top level holds the tag/valid/data arrays, the FSM, the fill counter and the memory-side mux.

## Test plan
- Miss fill: reset, then LW 0x100 (cold) → `stall` for 4 cycles. `mem_address` goes 0x100, 0x104, 0x108, 0x10C. Next cycle `read_data` = mem[0x100] and `stall` = 0.
- Extension: with word 0x80FF1234 at 0x100:
  - LB 0x103 → 0xFFFFFF80
  - LBU 0x103 → 0x00000080
  - LH 0x102 → 0xFFFF80FF
  - LHU 0x102 → 0x000080FF
  - LW 0x100 → 0x80FF1234
  - Every one of these loads must show `stall` = 0.
- Store hit: SW 0x104 = 0xDEADBEEF after a fill → `mem_write_enable` for 1 cycle with `mem_func3` = 2 and no stall. Then LW 0x104 → 0xDEADBEEF with no stall. Also SB 0x105 = 0x11, then LW 0x104 → 0xDEAD11EF.
- Store miss: SB 0x2000 cold → write to memory, no stall, no fill. Then LB 0x2000 → 4-cycle stall and the stored byte is returned.
- Conflict: fill 0x100, then LW 0x200 (same index 0) → miss and eviction. LW 0x100 → miss again (4 stall cycles).
- Corner cases:
  - LW 0x102 → `misaligned` = 1, `read_data` = 0, no stall, no memory write.
  - Assert `rst` in FILL cycle 2 → `stall` drops immediately. Repeating the same LW → full 4-cycle stall starting at 0x100.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
// Covers state encoding, RV32I load/store func3 codes and line geometry.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [2:0] F3_B  = 3'h0;
    localparam logic [2:0] F3_H  = 3'h1;
    localparam logic [2:0] F3_W  = 3'h2;
    localparam logic [2:0] F3_BU = 3'h4;
    localparam logic [2:0] F3_HU = 3'h5;

    localparam int LINE_WORDS = 4;
    localparam int BYTE_OFF_W = 2;
    localparam int WORD_OFF_W = 2;
    localparam int LINE_OFF_W = BYTE_OFF_W + WORD_OFF_W;

    function automatic logic is_misaligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        return ((f3[1:0] == 2'b01) && off[0])
            || ((f3 == F3_W) && (off != 2'b00));
    endfunction

    function automatic logic is_load_f3(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// Memory-stage request bus plus the data_memory side of the cache.
// master = pipeline/memory environment, slave = cache.
interface data_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_write;
    logic [2:0]            func3;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  stall;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [2:0]            mem_func3;
    logic                  mem_write_enable;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport master (
        output req_valid, req_write, func3, address,
        output write_data, mem_read_data,
        input  read_data, stall, misaligned,
        input  mem_address, mem_func3,
        input  mem_write_enable, mem_write_data
    );

    modport slave (
        input  req_valid, req_write, func3, address,
        input  write_data, mem_read_data,
        output read_data, stall, misaligned,
        output mem_address, mem_func3,
        output mem_write_enable, mem_write_data
    );
endinterface

// File: rtl/data_cache_load_align.sv
// Picks the byte/half/word out of a cached word and extends it per func3.
// Unknown load codes yield zero.
module load_align
    import cache_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{offset, 3'b000} +: 8];
    assign half_sel = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = '0;
        unique case (func3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            F3_W:    data = word;
            default: data = '0;
        endcase
    end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Load misses fill a 4-word line from data_memory, one word per cycle.
module data_cache
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = cache_pkg::LINE_WORDS
) (
    input  logic         clk,
    input  logic         rst,
    data_cache_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - LINE_OFF_W - IDX_W;
    localparam int CNT_W = $clog2(LINE_WORDS);

    logic                  valid_q [SETS];
    logic [TAG_W-1:0]      tag_q   [SETS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][LINE_WORDS];

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [WORD_OFF_W-1:0] wsel;
    logic [1:0]            off;
    logic                  mis, is_load, is_store;
    logic                  hit, start_fill, filling, last;
    logic [DATA_WIDTH-1:0] aligned;

    assign idx  = bus.address[LINE_OFF_W +: IDX_W];
    assign tag  = bus.address[ADDR_WIDTH-1 -: TAG_W];
    assign wsel = bus.address[BYTE_OFF_W +: WORD_OFF_W];
    assign off  = bus.address[1:0];

    assign mis      = bus.req_valid & is_misaligned(bus.func3, off);
    assign is_load  = bus.req_valid & ~bus.req_write & ~mis
                    & is_load_f3(bus.func3);
    assign is_store = bus.req_valid & bus.req_write & ~mis
                    & (state_q == IDLE);

    assign hit        = valid_q[idx] && (tag_q[idx] == tag);
    assign start_fill = (state_q == IDLE) & is_load & ~hit;
    // The miss cycle itself fetches word 0, so FILL only covers 1..3.
    assign filling    = (state_q == FILL) | start_fill;
    assign last       = (cnt_q == CNT_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_fill) state_d = FILL;
            FILL: if (last)       state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt_q <= '0;
        else if (filling) cnt_q <= cnt_q + 1'b1;
        else              cnt_q <= '0;
    end

    // Line is dropped while refilling so a reset mid-fill leaves it invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) valid_q[i] <= 1'b0;
        end else if (start_fill) begin
            valid_q[idx] <= 1'b0;
        end else if (filling && last) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && filling) begin
            data_q[idx][cnt_q] <= bus.mem_read_data;
            if (last) tag_q[idx] <= tag;
        end else if (!rst && is_store && hit) begin
            unique case (bus.func3)
                F3_B: data_q[idx][wsel][{off, 3'b000} +: 8]
                        <= bus.write_data[7:0];
                F3_H: data_q[idx][wsel][{off[1], 4'b0000} +: 16]
                        <= bus.write_data[15:0];
                F3_W: data_q[idx][wsel] <= bus.write_data;
                default: ;
            endcase
        end
    end

    load_align u_align (
        .word   (data_q[idx][wsel]),
        .offset (off),
        .func3  (bus.func3),
        .data   (aligned)
    );

    always_comb begin
        bus.read_data        = '0;
        bus.stall            = 1'b0;
        bus.misaligned       = 1'b0;
        bus.mem_address      = bus.address;
        bus.mem_func3        = bus.func3;
        bus.mem_write_enable = 1'b0;
        bus.mem_write_data   = bus.write_data;
        if (filling) begin
            bus.mem_address = {tag, idx, cnt_q, 2'b00};
            bus.mem_func3   = F3_W;
        end
        if (!rst) begin
            bus.stall            = filling;
            bus.misaligned       = mis;
            bus.mem_write_enable = is_store;
            if ((state_q == IDLE) && is_load && hit)
                bus.read_data = aligned;
        end
    end
endmodule
